// File: rtl/fetch_predict_pkg.sv
// fetch_predict_pkg: constants, BTB entry type and counter helper shared by
// the fetch stage (fetch_predict) and its branch target buffer (btb_table).
package fetch_predict_pkg;

  // Branch type as presented by decode on branchD.
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Widest tag (PC[31:4]) occurs at the smallest table of 4 entries; larger
  // tables store their shorter tag zero-extended to this width.
  localparam int TAG_MAXW = 28;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAXW-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } btb_entry_t;

  // Saturating step of a 2-bit counter towards taken or not taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

  // Tag of a PC for a table indexed by idxw bits: PC[31:idxw+2], zero-extended.
  function automatic logic [TAG_MAXW-1:0] tag_of(input logic [31:0] pc, input int idxw);
    return TAG_MAXW'(pc >> (idxw + 2));
  endfunction

endpackage

// File: rtl/fetch_predict_btb_table.sv
// btb_table: direct-mapped branch target buffer with 2-bit saturating
// counters. Combinational lookup port, one synchronous update port per cycle.
// The lookup always sees the contents from before a same-cycle update.
module btb_table
  import fetch_predict_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDXW = $clog2(ENTRIES);

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  logic [IDXW-1:0]     lookup_idx;
  logic [IDXW-1:0]     upd_idx;
  logic [TAG_MAXW-1:0] upd_tag;
  btb_entry_t          lookup_entry;
  btb_entry_t          upd_entry;
  logic                upd_hit;

  assign lookup_idx    = lookup_pc[IDXW+1:2];
  assign lookup_entry  = table_q[lookup_idx];
  assign lookup_taken  = lookup_entry.valid && (lookup_entry.tag == tag_of(lookup_pc, IDXW))
                         && lookup_entry.ctr[1];
  assign lookup_target = lookup_entry.target;

  assign upd_idx   = upd_pc[IDXW+1:2];
  assign upd_tag   = tag_of(upd_pc, IDXW);
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // Next table contents: train the hit entry or allocate over the indexed one.
  always_comb begin
    // NOTE: table_d starts as a full copy of table_q so every path assigns it and no latch is inferred.
    table_d = table_q;
    if (upd_en) begin
      if (upd_hit) begin
        table_d[upd_idx].ctr    = ctr_step(upd_entry.ctr, upd_taken);
        table_d[upd_idx].target = upd_target;
      end else begin
        table_d[upd_idx].valid  = 1'b1;
        table_d[upd_idx].tag    = upd_tag;
        table_d[upd_idx].target = upd_target;
        table_d[upd_idx].ctr    = upd_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

  // Table storage with asynchronous clear of every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every entry (counter included) is reset, so this table is built from flops, not a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].ctr    <= CTR_WNT;
      end
    end else begin
      // NOTE: sequential state uses <= so all flops sample pre-edge values regardless of statement order.
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// fetch_predict: fetch stage of the pipelined MIPS core. Owns the PC and the
// next-PC mux (decode redirects, stall, BTB prediction, sequential).
// Build option FETCH_BTB_PREDICT_EN: when defined a btb_table supplies dynamic
// taken predictions; when undefined no BTB is built and fetch predicts static
// not-taken. The port list is the same in both builds.
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter int          BTB_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        misspredict,
  input  logic        jumpD,
  input  logic [27:0] jumpdstD,
  input  logic [1:0]  branchD,
  input  logic        pcsrcD,
  input  logic        predict_takenD,
  input  logic [31:0] pcbranchD,
  input  logic [31:0] pcplus4D,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F,
  output logic        predict_takenF
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        unused_inputs;

  assign pcF      = pc_q;
  assign pcplus4F = pc_q + 32'd4;

`ifdef FETCH_BTB_PREDICT_EN
  logic [31:0] pcD;
  logic        train_en;

  assign pcD      = pcplus4D - 32'd4;
  assign train_en = (branchD != BR_NONE) && !stallD;

  btb_table #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc    (pc_q),
    .lookup_taken (pred_taken),
    .lookup_target(pred_target),
    .upd_en       (train_en),
    .upd_pc       (pcD),
    .upd_taken    (pcsrcD),
    .upd_target   (pcbranchD)
  );

  // The prediction carried into decode is consumed by decode itself.
  assign unused_inputs = predict_takenD;
`else
  // Static not-taken: the predicted path is simply the sequential one.
  assign pred_taken  = 1'b0;
  assign pred_target = pcplus4F;

  // Inputs and sizing that only matter when the BTB is built.
  assign unused_inputs = ^{branchD, predict_takenD, 32'(BTB_ENTRIES)};
`endif

  assign predict_takenF = pred_taken;

  // Next-PC priority: decode redirects beat the fetch stall, which beats prediction.
  always_comb begin
    pc_d = pcplus4F;
    if (misspredict && !stallD) begin
      pc_d = pcsrcD ? pcbranchD : pcplus4D;
    end else if (jumpD && !stallD) begin
      pc_d = {pcplus4D[31:28], jumpdstD};
    end else if (stallF) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // PC register, asynchronously loaded with RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_predict.sv
// tb_fetch_predict: table-driven bench for fetch_predict with a scoreboard of
// expected pcF / predict_takenF values. Each record holds the expectation for
// both builds (with and without FETCH_BTB_PREDICT_EN); the bench picks the one
// matching how it was compiled.
module tb_fetch_predict;
  import fetch_predict_pkg::*;

`ifdef FETCH_BTB_PREDICT_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, misspredict, jumpD, pcsrcD, predict_takenD;
  logic [27:0] jumpdstD;
  logic [1:0]  branchD;
  logic [31:0] pcbranchD, pcplus4D;
  logic [31:0] pcF, pcplus4F;
  logic        predict_takenF;

  fetch_predict dut (
    .clk           (clk),
    .reset         (reset),
    .stallF        (stallF),
    .stallD        (stallD),
    .misspredict   (misspredict),
    .jumpD         (jumpD),
    .jumpdstD      (jumpdstD),
    .branchD       (branchD),
    .pcsrcD        (pcsrcD),
    .predict_takenD(predict_takenD),
    .pcbranchD     (pcbranchD),
    .pcplus4D      (pcplus4D),
    .pcF           (pcF),
    .pcplus4F      (pcplus4F),
    .predict_takenF(predict_takenF)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the state expected after the next rising edge.
  typedef struct {
    logic        sf, sd, mp, jd;
    logic [27:0] jdst;
    logic [1:0]  br;
    logic        ps, pt;
    logic [31:0] pb, p4d;
    logic [31:0] pc_en;   // expected pcF with the BTB built
    logic        pr_en;   // expected predict_takenF with the BTB built
    logic [31:0] pc_dis;  // expected pcF with static not-taken
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total;
  int   bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sf, sd, mp, jd, input logic [27:0] jdst,
                              input logic [1:0] br, input logic ps, pt,
                              input logic [31:0] pb, p4d, pc_en, input logic pr_en,
                              input logic [31:0] pc_dis);
    vec_t v;
    v.sf = sf; v.sd = sd; v.mp = mp; v.jd = jd; v.jdst = jdst; v.br = br;
    v.ps = ps; v.pt = pt; v.pb = pb; v.p4d = p4d;
    v.pc_en = pc_en; v.pr_en = pr_en; v.pc_dis = pc_dis;
    return v;
  endfunction

  function automatic vec_t idle_v(input logic [31:0] pc_en, input logic pr_en, input logic [31:0] pc_dis);
    return mk(0, 0, 0, 0, 28'h0, BR_NONE, 0, 0, 32'h0, 32'h0, pc_en, pr_en, pc_dis);
  endfunction

  function automatic vec_t jump_v(input logic [27:0] dst, input logic [31:0] p4d,
                                  input logic [31:0] pc, input logic pr_en);
    return mk(0, 0, 0, 1, dst, BR_NONE, 0, 0, 32'h0, p4d, pc, pr_en, pc);
  endfunction

  task automatic drive(input vec_t v);
    stallF = v.sf; stallD = v.sd; misspredict = v.mp; jumpD = v.jd;
    jumpdstD = v.jdst; branchD = v.br; pcsrcD = v.ps; predict_takenD = v.pt;
    pcbranchD = v.pb; pcplus4D = v.p4d;
  endtask

  // Drive at the falling edge, expect the result after the next rising edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    drive(v);
    e.name = name;
    e.pc   = BTB_EN ? v.pc_en : v.pc_dis;
    e.pred = BTB_EN ? v.pr_en : 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".pcF"}, pcF, e.pc);
    check({e.name, ".pcplus4F"}, pcplus4F, e.pc + 32'd4);
    check({e.name, ".pred"}, {31'b0, predict_takenF}, {31'b0, e.pred});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(idle_v(0, 0, 0));

    // Free running from reset.
    vecs.push_back(idle_v(32'h4, 0, 32'h4));
    vecs.push_back(idle_v(32'h8, 0, 32'h8));
    vecs.push_back(idle_v(32'hC, 0, 32'hC));
    // beq at 0x10 taken but predicted not taken: redirect, install ctr=10.
    vecs.push_back(mk(0, 0, 1, 0, 28'h0, BR_BEQ, 1, 0, 32'h40, 32'h14, 32'h40, 0, 32'h40));
    vecs.push_back(jump_v(28'h10, 32'h4, 32'h10, 1));
    vecs.push_back(idle_v(32'h40, 0, 32'h14));
    // Predicted taken, resolved not taken: back to pcplus4D, ctr 10 -> 01.
    vecs.push_back(mk(0, 0, 1, 0, 28'h0, BR_BEQ, 0, 1, 32'h40, 32'h14, 32'h14, 0, 32'h14));
    // Not taken again, no redirect: ctr 01 -> 00.
    vecs.push_back(mk(0, 0, 0, 0, 28'h0, BR_BEQ, 0, 0, 32'h40, 32'h14, 32'h18, 0, 32'h18));
    vecs.push_back(jump_v(28'h10, 32'h8, 32'h10, 0));
    vecs.push_back(idle_v(32'h14, 0, 32'h14));
    // Four taken resolutions: 00 -> 01 -> 10 -> 11 -> 11.
    vecs.push_back(mk(0, 0, 1, 0, 28'h0, BR_BEQ, 1, 0, 32'h40, 32'h14, 32'h40, 0, 32'h40));
    vecs.push_back(mk(0, 0, 1, 0, 28'h0, BR_BEQ, 1, 0, 32'h40, 32'h14, 32'h40, 0, 32'h40));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0, BR_BEQ, 1, 1, 32'h40, 32'h14, 32'h44, 0, 32'h44));
    vecs.push_back(mk(0, 0, 0, 0, 28'h0, BR_BNE, 1, 1, 32'h40, 32'h14, 32'h48, 0, 32'h48));
    vecs.push_back(jump_v(28'h10, 32'h8, 32'h10, 1));
    // Misprediction beats the taken prediction at pcF; ctr 11 -> 10.
    vecs.push_back(mk(0, 0, 1, 0, 28'h0, BR_BEQ, 0, 1, 32'h40, 32'h14, 32'h14, 0, 32'h14));
    vecs.push_back(jump_v(28'h10, 32'h8, 32'h10, 1));
    // stallF holds the PC over a taken prediction.
    vecs.push_back(mk(1, 0, 0, 0, 28'h0, BR_NONE, 0, 0, 32'h0, 32'h0, 32'h10, 1, 32'h10));
    vecs.push_back(idle_v(32'h40, 0, 32'h14));
    // jal keeps pcplus4D[31:28].
    vecs.push_back(jump_v(28'h0000100, 32'h2000_0008, 32'h2000_0100, 0));
    // stallD gates jump and misprediction; stallF holds; no training.
    vecs.push_back(mk(1, 1, 0, 1, 28'h10, BR_NONE, 0, 0, 32'h0, 32'h8, 32'h2000_0100, 0, 32'h2000_0100));
    vecs.push_back(mk(1, 1, 1, 0, 28'h0, BR_BEQ, 1, 0, 32'h80, 32'h124, 32'h2000_0100, 0, 32'h2000_0100));
    // Redirect overrides stallF; branch at 0x110 overwrites index 4 (tag 1).
    vecs.push_back(mk(1, 0, 1, 0, 28'h0, BR_BEQ, 1, 0, 32'h200, 32'h114, 32'h200, 0, 32'h200));
    vecs.push_back(jump_v(28'h120, 32'h8, 32'h120, 0));
    vecs.push_back(jump_v(28'h10, 32'h8, 32'h10, 0));
    vecs.push_back(jump_v(28'h110, 32'h8, 32'h110, 1));
    // Bubble with pcsrcD set must not train.
    vecs.push_back(mk(0, 0, 0, 0, 28'h0, BR_NONE, 1, 0, 32'h300, 32'h34, 32'h200, 0, 32'h114));
    vecs.push_back(jump_v(28'h30, 32'h8, 32'h30, 0));
    // Earlier jal from 0x20000004 was never installed.
    vecs.push_back(jump_v(28'h4, 32'h2000_0000, 32'h2000_0004, 0));
    // pcplus4F wraps at 2^32.
    vecs.push_back(jump_v(28'hFFF_FFFC, 32'hF000_0000, 32'hFFFF_FFFC, 0));
    vecs.push_back(idle_v(32'h0, 0, 32'h0));

    // Reset holds the PC even with a jump presented.
    @(negedge clk);
    jumpD = 1'b1; jumpdstD = 28'h100;
    @(negedge clk);
    check("reset.pcF", pcF, RESET_PC_DEFAULT);
    check("reset.pcplus4F", pcplus4F, 32'h4);
    check("reset.pred", {31'b0, predict_takenF}, 32'h0);
    drive(idle_v(0, 0, 0));
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Same-cycle lookup and update at index 12: lookup sees the old miss.
    apply(jump_v(28'h30, 32'h8, 32'h30, 0), "rbw_jump");
    apply(mk(0, 0, 0, 0, 28'h0, BR_BEQ, 1, 0, 32'h300, 32'h34, 32'h34, 0, 32'h34), "rbw_same");
    apply(jump_v(28'h30, 32'h8, 32'h30, 1), "rbw_next");

    // Asynchronous reset mid-cycle while a training update is pending.
    drive(mk(0, 0, 0, 0, 28'h0, BR_BEQ, 1, 0, 32'h300, 32'h34, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("midreset.pcF", pcF, RESET_PC_DEFAULT);
    check("midreset.pred", {31'b0, predict_takenF}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("midreset.hold", pcF, RESET_PC_DEFAULT);
    drive(idle_v(0, 0, 0));
    reset = 1'b0;
    apply(jump_v(28'h30, 32'h8, 32'h30, 0), "after_reset");
    apply(jump_v(28'h10, 32'h8, 32'h10, 0), "after_reset_idx4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
